// File: rtl/i2c_audio_master.sv
// i2c_audio_master: single-master I2C reader fetching one 16-bit audio sample
// per start_i request (START, address+R, two data bytes, ACK then NACK, STOP).
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour slave clock
// stretching (quarter-tick counter waits for scl_i high after SCL release).
module i2c_audio_master #(
  parameter logic [6:0]  I2C_SLAVE_ADDRESS = 7'h45,
  parameter int unsigned CLK_DIV           = 125
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        scl_i,
  output logic        scl_o,
  output logic        scl_t,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic [15:0] audio_data_o,
  output logic        audio_valid_o,
  output logic        busy_o,
  output logic        nack_o
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, DATA_HI, ACK_HI, DATA_LO, NACK_LO, STOP, DONE
  } state_t;

  localparam logic [7:0]  ADDR_BYTE = {I2C_SLAVE_ADDRESS, 1'b1};
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);

  state_t      r_state;
  logic [15:0] r_qcnt;
  logic [1:0]  r_q;
  logic [2:0]  r_bitcnt;
  logic [15:0] r_shift;
  logic        r_acked;
  logic        r_scl_t;
  logic        r_sda_t;
  logic [15:0] r_data;
  logic        r_valid;
  logic        r_busy;
  logic        r_nack;

  logic        w_tick;
  logic        w_hold;
  logic        w_sda_bit;

`ifdef I2C_CLOCK_STRETCH_EN
  // SCL was released at Q1; wait here while a slave keeps it low.
  assign w_hold = (r_q == 2'd2) && !scl_i;
`else
  logic w_unused_scl;
  assign w_unused_scl = scl_i;
  assign w_hold       = 1'b0;
`endif

  assign w_tick = (r_state != IDLE) && !w_hold && (r_qcnt == DIV_LAST);

  // SDA level to present at Q0 of the current bit (1 = released).
  always_comb begin
    w_sda_bit = 1'b1;
    case (r_state)
      ADDR:    w_sda_bit = ADDR_BYTE[r_bitcnt];
      ACK_HI:  w_sda_bit = 1'b0;
      default: w_sda_bit = 1'b1;
    endcase
  end

  // Quarter-period divider: runs only while busy, frozen during a stretch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_qcnt <= '0;
    end else if (r_state == IDLE) begin
      r_qcnt <= '0;
    end else if (w_hold) begin
      r_qcnt <= r_qcnt;
    end else if (r_qcnt == DIV_LAST) begin
      r_qcnt <= '0;
    end else begin
      r_qcnt <= r_qcnt + 16'd1;
    end
  end

  // Transaction FSM with registered line controls and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_acked  <= 1'b0;
      r_scl_t  <= 1'b1;
      r_sda_t  <= 1'b1;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_nack   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_nack  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_q <= '0;
          if (start_i) begin
            r_state  <= START;
            r_busy   <= 1'b1;
            r_bitcnt <= 3'd7;
            r_acked  <= 1'b0;
            r_shift  <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_q == 2'd0) begin
              r_sda_t <= 1'b0;
              r_q     <= 2'd1;
            end else begin
              r_scl_t <= 1'b0;
              r_q     <= 2'd0;
              r_state <= ADDR;
            end
          end
        end
        ADDR, ADDR_ACK, DATA_HI, ACK_HI, DATA_LO, NACK_LO: begin
          if (w_tick) begin
            r_q <= r_q + 2'd1;
            case (r_q)
              2'd0: r_sda_t <= w_sda_bit;
              2'd1: r_scl_t <= 1'b1;
              2'd2: begin
                if (r_state == ADDR_ACK) begin
                  r_acked <= !sda_i;
                end else if (r_state == DATA_HI || r_state == DATA_LO) begin
                  r_shift <= {r_shift[14:0], sda_i};
                end
              end
              default: begin
                r_scl_t <= 1'b0;
                case (r_state)
                  ADDR: begin
                    if (r_bitcnt == 3'd0) r_state <= ADDR_ACK;
                    else r_bitcnt <= r_bitcnt - 3'd1;
                  end
                  ADDR_ACK: begin
                    r_bitcnt <= 3'd7;
                    if (r_acked) begin
                      r_state <= DATA_HI;
                    end else begin
                      r_nack  <= 1'b1;
                      r_state <= STOP;
                    end
                  end
                  DATA_HI: begin
                    if (r_bitcnt == 3'd0) r_state <= ACK_HI;
                    else r_bitcnt <= r_bitcnt - 3'd1;
                  end
                  ACK_HI: begin
                    r_bitcnt <= 3'd7;
                    r_state  <= DATA_LO;
                  end
                  DATA_LO: begin
                    if (r_bitcnt == 3'd0) r_state <= NACK_LO;
                    else r_bitcnt <= r_bitcnt - 3'd1;
                  end
                  default: r_state <= STOP;
                endcase
              end
            endcase
          end
        end
        STOP: begin
          // SCL is low on entry: pull SDA low first so the SCL release
          // cannot be mistaken for a repeated START.
          if (w_tick) begin
            case (r_q)
              2'd0: begin
                r_sda_t <= 1'b0;
                r_q     <= 2'd1;
              end
              2'd1: begin
                r_scl_t <= 1'b1;
                r_q     <= 2'd2;
              end
              default: begin
                r_sda_t <= 1'b1;
                r_q     <= 2'd0;
                r_state <= DONE;
              end
            endcase
          end
        end
        DONE: begin
          // Address ACK implies the full read ran; NACK leaves data untouched.
          if (r_acked) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
          end
          r_bitcnt <= '0;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scl_o         = 1'b0;
  assign sda_o         = 1'b0;
  assign scl_t         = r_scl_t;
  assign sda_t         = r_sda_t;
  assign audio_data_o  = r_data;
  assign audio_valid_o = r_valid;
  assign busy_o        = r_busy;
  assign nack_o        = r_nack;

endmodule

// File: doc/i2c_audio_master.md
I2C_AUDIO_MASTER -- requirements
Module: i2c_audio_master

Interface
REQ-001 The block SHALL have parameter I2C_SLAVE_ADDRESS, default 7'h45, the 7-bit target address.
REQ-002 The block SHALL have parameter CLK_DIV, default 125, the number of clk cycles per SCL quarter-period; legal range is 2..65535.
REQ-003 clk  in  1  the single system clock; all state SHALL be updated on the rising edge of clk.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 start_i  in  1  one-cycle request to read one 16-bit sample.
REQ-006 scl_i  in  1  sampled SCL line level.
REQ-007 scl_o  out  1  SCL drive value; the block SHALL hold it at constant 0.
REQ-008 scl_t  out  1  SCL tristate enable: 1 = released, 0 = drive scl_o.
REQ-009 sda_i  in  1  sampled SDA line level.
REQ-010 sda_o  out  1  SDA drive value; the block SHALL hold it at constant 0.
REQ-011 sda_t  out  1  SDA tristate enable: 1 = released, 0 = drive low.
REQ-012 audio_data_o  out  16  last received sample, MSB first on the bus.
REQ-013 audio_valid_o  out  1  one-cycle strobe marking a new audio_data_o.
REQ-014 busy_o  out  1  high whenever the state is not IDLE.
REQ-015 nack_o  out  1  one-cycle strobe when the address is not acknowledged.

Function
REQ-016 A quarter-tick SHALL pulse once every CLK_DIV clk cycles while busy_o=1; the tick counter SHALL be cleared in IDLE.
REQ-017 Each bit SHALL span 4 quarter-ticks:
- Q0: SCL low, update SDA.
- Q1: release SCL.
- Q2: sample sda_i.
- Q3: drive SCL low.
REQ-018 The FSM states SHALL be IDLE, START, ADDR, ADDR_ACK, DATA_HI, ACK_HI, DATA_LO, NACK_LO, STOP, DONE.
REQ-019 IDLE: start_i=1 SHALL enter START; start_i SHALL be ignored in every other state.
REQ-020 START: SDA SHALL fall while SCL is released, then SCL SHALL fall one quarter-period later, then the FSM SHALL go to ADDR.
REQ-021 ADDR: the FSM SHALL shift out {I2C_SLAVE_ADDRESS, 1'b1} (8 bits, MSB first), then go to ADDR_ACK.
REQ-022 ADDR_ACK: SDA SHALL be released.
- If sda_i=0 at Q2, the FSM SHALL go to DATA_HI.
- Otherwise it SHALL pulse nack_o and go to STOP.
REQ-023 DATA_HI/DATA_LO: SDA SHALL be released and 8 bits each shifted into a 16-bit register at Q2, MSB first.
REQ-024 ACK_HI: the master SHALL drive SDA low for one bit (ACK); NACK_LO: it SHALL release SDA for one bit (NACK).
REQ-025 STOP: SDA SHALL be low with SCL released, then SDA SHALL be released one quarter-period later, then the FSM SHALL go to DONE.
REQ-026 DONE: on a successful read, audio_data_o SHALL load the shift register, audio_valid_o SHALL pulse for exactly 1 clk, and the FSM SHALL go to IDLE.
REQ-027 After a NACK, DONE SHALL return to IDLE without a valid strobe, and audio_data_o SHALL be unchanged.
REQ-028 Bit counters SHALL count 7 down to 0 and SHALL not wrap into the next field.
REQ-029 audio_data_o SHALL hold its value until the next successful read.
REQ-030 scl_t and sda_t SHALL be registered, with no combinational path from any input.

Reset
REQ-031 On rst_n=0, the block SHALL immediately set: state=IDLE, scl_t=1, sda_t=1, audio_data_o=16'h0000, audio_valid_o=0, busy_o=0, nack_o=0, all counters 0.
REQ-032 A reset mid-transaction SHALL release both lines at once, and SHALL generate no STOP and no strobe.
REQ-033 After rst_n rises, the block SHALL accept start_i on the first clk edge.

Configuration
REQ-034 With macro I2C_CLOCK_STRETCH_EN defined: at Q1, after releasing SCL, the quarter-tick counter SHALL hold until scl_i=1 (slave clock stretching), and Q2 SHALL start CLK_DIV cycles after scl_i is seen high.
REQ-035 With I2C_CLOCK_STRETCH_EN undefined, scl_i SHALL be ignored and the timing SHALL be purely counter-driven.

Verification
REQ-036 Reset: hold rst_n=0 -> scl_t=1, sda_t=1, audio_data_o=0, busy_o=0.
REQ-037 Normal read: CLK_DIV=4, slave model at 7'h45 ACKs and returns 8'hA5, 8'h5A -> bus shows address byte 8'h8B, master ACK after byte 1, NACK after byte 2, STOP; audio_data_o=16'hA55A with a 1-clk audio_valid_o; total 9+9+9 bits plus START/STOP.
REQ-038 Address NACK: slave never ACKs -> nack_o pulses once, STOP is issued, no audio_valid_o, audio_data_o keeps its previous value.
REQ-039 Start while busy: pulse start_i mid-DATA_HI -> ignored; exactly one transaction completes.
REQ-040 Reset mid-transaction: assert rst_n=0 during DATA_LO -> scl_t=1 and sda_t=1 the same cycle; a following read returns the correct sample.
REQ-041 Clock stretch (I2C_CLOCK_STRETCH_EN defined): slave holds SCL low 50 clk during ADDR_ACK -> the master waits, then completes the read with the correct data.
